// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, 2-entry fetch buffer, redirect flush.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirects into FAULT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_rdy,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  count;
  logic        hd, tl;
  logic [31:0] bpc [2];
  logic [31:0] bin [2];
  logic        pop, fetch;
  logic [31:0] tgt;
  logic [1:0]  count_nxt;

  assign imem_addr = pc;
  assign if_valid  = (count != 2'd0);
  assign if_pc     = bpc[hd];
  assign if_instr  = bin[hd];
  assign pop       = if_valid && if_ready;
  assign fetch     = (state == RUN) && imem_rdy && !redirect_valid
                     && ((count != 2'd2) || pop);

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis;
  assign tgt = redirect_pc;
  assign mis = |redirect_pc[1:0];
`else
  // Low bits are dropped so the PC can never become misaligned.
  assign tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  always_comb begin
    count_nxt = count;
    unique case ({fetch, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      count  <= 2'd0;
      hd     <= 1'b0;
      tl     <= 1'b0;
      bpc[0] <= 32'd0;
      bpc[1] <= 32'd0;
      bin[0] <= 32'd0;
      bin[1] <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end
`ifdef FETCH_ALIGN_CHECK_EN
    else if (state == FAULT) begin
      count <= 2'd0;
    end
`endif
    else if (redirect_valid) begin
      count <= 2'd0;
      hd    <= 1'b0;
      tl    <= 1'b0;
      pc    <= tgt;
`ifdef FETCH_ALIGN_CHECK_EN
      if (mis) begin
        state       <= FAULT;
        fetch_fault <= 1'b1;
      end else begin
        state <= RUN;
      end
`else
      state <= RUN;
`endif
    end else begin
      state <= RUN;
      count <= count_nxt;
      if (fetch) begin
        bpc[tl] <= pc;
        bin[tl] <= imem_instr;
        tl      <= ~tl;
        pc      <= pc + 32'd4;
      end
      if (pop) hd <= ~hd;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Memory word at byte address A is 32'h1000_0000 + A/4.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_rdy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int ncmp = 0;
  int nfail = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .imem_rdy       (imem_rdy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_instr = mem(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    imem_rdy = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    repeat (2) step();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    reset = 1'b0;

    step();
    chk("boot_valid", {31'd0, if_valid}, 32'd0);
    chk("boot_addr", imem_addr, 32'h0);
    step();
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, mem(32'h0));
    step();
    chk("seq_pc4", if_pc, 32'h4);
    chk("seq_in4", if_instr, mem(32'h4));
    step();
    chk("seq_pc8", if_pc, 32'h8);
    chk("seq_in8", if_instr, mem(32'h8));

    if_ready = 1'b0;
    redir(32'h0);
    chk("rd0_valid", {31'd0, if_valid}, 32'd0);
    chk("rd0_addr", imem_addr, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_head", if_pc, 32'h0);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
    end
    if_ready = 1'b1;
    step();
    chk("drain_pc4", if_pc, 32'h4);
    step();
    chk("drain_pc8", if_pc, 32'h8);
    chk("drain_in8", if_instr, mem(32'h8));

    if_ready = 1'b0;
    step();
    chk("full_addr", imem_addr, 32'h10);
    chk("full_head", if_pc, 32'h8);
    redir(32'h40);
    if_ready = 1'b1;
    chk("rdf_valid", {31'd0, if_valid}, 32'd0);
    chk("rdf_addr", imem_addr, 32'h40);
    step();
    chk("rdf_pc", if_pc, 32'h40);
    chk("rdf_instr", if_instr, 32'h1000_0010);

    redir(32'h80);
    chk("rdp_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("rdp_pc80", if_pc, 32'h80);
    step();
    chk("rdp_pc84", if_pc, 32'h84);
    imem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nordy_addr", imem_addr, 32'h88);
      chk("nordy_valid", {31'd0, if_valid}, 32'd0);
    end
    imem_rdy = 1'b1;
    step();
    chk("rdy_pc88", if_pc, 32'h88);
    chk("rdy_valid", {31'd0, if_valid}, 32'd1);
    step();
    chk("rdy_pc8c", if_pc, 32'h8C);

    redir(32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_addr, 32'h0);
    step();
    chk("wrap_pc0", if_pc, 32'h0);

    redir(32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_valid", {31'd0, if_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h42);
    redir(32'h100);
    chk("flt_addr", imem_addr, 32'h42);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flt_valid", {31'd0, if_valid}, 32'd0);
      chk("flt_fault", {31'd0, fetch_fault}, 32'd1);
    end
`else
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("mis_pc", if_pc, 32'h40);
    chk("mis_instr", if_instr, 32'h1000_0010);
    step();
    chk("mis_pc44", if_pc, 32'h44);
`endif

    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_instr", if_instr, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("arst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    step();
    chk("post_pc", if_pc, 32'h0);
    chk("post_valid", {31'd0, if_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. It sits directly upstream of the combinational instruction memory and drives its address. It captures each returned instruction word together with its PC into a 2-entry fetch buffer and hands it to decode over a valid/ready handshake. Branch and jump redirects from execute flush the buffer and restart fetch at the target.

## Interface
- RESET_PC, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  fetch address to instruction memory; equals the PC register.
- imem_instr  input  32  instruction word from memory; combinational from imem_addr.
- imem_rdy  input  1  memory ready; a fetch is accepted only when high.
- redirect_valid  input  1  branch/jump taken; load redirect_pc this cycle.
- redirect_pc  input  32  redirect target.
- if_valid  output  1  buffer head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction word.
- if_pc  output  32  head PC.
- fetch_fault  output  1  sticky misaligned-redirect fault; exists only with FETCH_ALIGN_CHECK_EN.

## Operation
- FSM states: BOOT, RUN, FAULT. FAULT is reachable only with FETCH_ALIGN_CHECK_EN.
- BOOT: entered on reset. No fetch occurs. The FSM moves to RUN unconditionally on the first clock edge after reset deasserts.
- RUN: the fetch buffer has 2 entries, each {pc, instr}, with a count of 0..2.
- pop = if_valid && if_ready.
- fetch = RUN && imem_rdy && !redirect_valid && (count<2 || pop). On fetch, {pc, imem_instr} is pushed at the tail and pc <= pc + 4.
- PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- redirect_valid in RUN or BOOT:
  - count <= 0 and pc <= redirect_pc.
  - Any concurrent pop or push is discarded.
  - Redirect has priority over everything except reset.
- Simultaneous push and pop updates the head/tail pointers; count is unchanged.
- count==2 without a pop: no fetch, and pc holds.
- imem_rdy low: no fetch, and pc holds. The buffer can still drain.
- if_valid = (count!=0). if_instr and if_pc come from the head entry. When if_valid is low, their values are don't-care but must not be X after reset.
- Decode must keep if_ready meaningful only while if_valid is high. The head is stable while if_valid && !if_ready.

## Timing
- Reset values:
  - state=BOOT, pc=RESET_PC, imem_addr=RESET_PC.
  - count=0, if_valid=0.
  - if_instr=0, if_pc=0, fetch_fault=0.
- Fetch latency: an instruction fetched in cycle N has if_valid high in cycle N+1.
- After reset deassertion, the first if_valid is 2 cycles after the first clock edge: one cycle in BOOT, then the fetch cycle.
- Redirect asserted in cycle N:
  - if_valid is 0 in cycle N+1.
  - imem_addr = target in cycle N+1.
  - The target instruction is valid in cycle N+2.
- Steady throughput is 1 instruction per cycle when imem_rdy=1 and if_ready=1.
- Reset asserted mid-operation immediately clears all state, including buffer contents and fault, with no clock required.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 moves the FSM to FAULT.
  - fetch_fault <= 1 (sticky), count <= 0, pc <= redirect_pc.
  - In FAULT there is no fetch, if_valid=0, and further redirects are ignored.
  - Only reset exits FAULT.
- FETCH_ALIGN_CHECK_EN undefined:
  - The fetch_fault port is absent.
  - redirect_pc[1:0] is forced to 2'b00 on load.
  - FAULT does not exist.

## Test plan
- Reset, then hold if_ready=1 and imem_rdy=1 with memory holding words at 0x00/0x04/0x08 -> if_valid rises 2 cycles after the first clock edge after reset release, followed by if_pc 0,4,8 on consecutive cycles with the matching words.
- Hold if_ready=0 for 5 cycles -> count saturates at 2, imem_addr stays at 0x08, and the head stays at pc=0. Releasing if_ready then drains 0,4 in order with no gap before pc 8.
- With the buffer full, assert redirect_valid with target 0x40 -> if_valid is 0 the next cycle, and the cycle after that shows if_pc=0x40 with mem[0x10].
- Assert redirect_valid and pop in the same cycle -> the popped entry is dropped and no stale PC appears afterward. Toggle imem_rdy low for 3 cycles -> pc holds and there are no duplicate PCs.
- Start from pc=32'hFFFF_FFFC -> the next fetch address is 0.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fetch_fault=1 and if_valid stays 0 until reset. Without the macro, the same redirect fetches 0x40.
